// File: rtl/avmm_xfer_pkg.sv
// rtl/avmm_xfer_pkg.sv - shared types and constants for the AVMM transfer engine
// Holds the engine state encoding, CSR word offsets and CTRL/STATUS bit positions.
package avmm_xfer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR      = 2'd1,
    RD_REQ  = 2'd2,
    RD_WAIT = 2'd3
  } state_t;

  // CSR word offsets within the lower half of the slave window
  localparam int CSR_CTRL      = 0;
  localparam int CSR_STATUS    = 1;
  localparam int CSR_BASE_ADDR = 2;
  localparam int CSR_COUNT     = 3;

  // CTRL bit positions
  localparam int CTRL_START  = 0;
  localparam int CTRL_DIR    = 1;
  localparam int CTRL_ABORT  = 2;
  localparam int CTRL_IRQ_EN = 3;

  // STATUS bit positions
  localparam int STAT_BUSY      = 0;
  localparam int STAT_DONE      = 1;
  localparam int STAT_ERROR     = 2;
  localparam int STAT_ABORTED   = 3;
  localparam int STAT_WORDS_LSB = 8;

endpackage

// File: rtl/xfer_buffer.sv
// rtl/xfer_buffer.sv - NUMWORDS x DATAWIDTH local buffer for the transfer engine
// Ports: clk; slave write side (slv_we/slv_addr/slv_wdata); engine write side
// (eng_we/eng_addr/eng_wdata, wins when both are active); two asynchronous read
// ports (rd_addr_a/rd_data_a for the slave, rd_addr_b/rd_data_b for the engine).
module xfer_buffer
  import avmm_xfer_pkg::*;
#(
  parameter int NUMWORDS  = 16,
  parameter int DATAWIDTH = 32,
  localparam int AW       = $clog2(NUMWORDS)
) (
  input  logic                 clk,
  input  logic                 slv_we,
  input  logic [AW-1:0]        slv_addr,
  input  logic [DATAWIDTH-1:0] slv_wdata,
  input  logic                 eng_we,
  input  logic [AW-1:0]        eng_addr,
  input  logic [DATAWIDTH-1:0] eng_wdata,
  input  logic [AW-1:0]        rd_addr_a,
  output logic [DATAWIDTH-1:0] rd_data_a,
  input  logic [AW-1:0]        rd_addr_b,
  output logic [DATAWIDTH-1:0] rd_data_b
);

  logic [DATAWIDTH-1:0] mem [NUMWORDS];

  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic [DATAWIDTH-1:0] wr_data;

  // The top never lets both sides write in the same cycle (slave buffer
  // writes are dropped while busy), but the engine is given priority anyway.
  assign wr_en   = eng_we | slv_we;
  assign wr_addr = eng_we ? eng_addr  : slv_addr;
  assign wr_data = eng_we ? eng_wdata : slv_wdata;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = mem[rd_addr_a];
  assign rd_data_b = mem[rd_addr_b];

endmodule

// File: rtl/avmm_xfer_engine.sv
// rtl/avmm_xfer_engine.sv - CSR-programmed block mover between a local buffer and an AVMM master
// Ports: clk, reset (sync, active-high); slave_* CSR/buffer window (lower half CSRs,
// upper half buffer words, read data one cycle after a selected read); master_* single
// outstanding AVMM master honouring waitrequest; irq = STATUS.done & CTRL.irq_en.
module avmm_xfer_engine
  import avmm_xfer_pkg::*;
#(
  parameter int          MASTER_ADDRESSWIDTH = 26,
  parameter int          DATAWIDTH           = 32,
  parameter int          NUMWORDS            = 16,
  parameter logic [31:0] BASE_RESET          = 32'h08000000,
  localparam int         SLAVE_ADDRESSWIDTH  = $clog2(NUMWORDS) + 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [SLAVE_ADDRESSWIDTH-1:0]  slave_address,
  input  logic [DATAWIDTH-1:0]           slave_writedata,
  input  logic                           slave_write,
  input  logic                           slave_read,
  input  logic                           slave_chipselect,
  output logic [DATAWIDTH-1:0]           slave_readdata,
  output logic [MASTER_ADDRESSWIDTH-1:0] master_address,
  output logic [DATAWIDTH-1:0]           master_writedata,
  output logic                           master_write,
  output logic                           master_read,
  input  logic [DATAWIDTH-1:0]           master_readdata,
  input  logic                           master_readdatavalid,
  input  logic                           master_waitrequest,
  output logic                           irq
);

  localparam int BAW   = SLAVE_ADDRESSWIDTH - 1;  // buffer index / CSR offset width
  localparam int IW    = BAW + 1;                 // idx must be able to hold NUMWORDS
  localparam int BYTES = DATAWIDTH / 8;

  state_t state, next_state;

  logic                           dir_q, irq_en_q;
  logic                           done_q, error_q, aborted_q, abort_pend;
  logic [MASTER_ADDRESSWIDTH-1:0] base_addr;
  logic [DATAWIDTH-1:0]           count_q;
  logic [IW-1:0]                  idx, xfer_len;

  // Slave decode
  logic           slv_wr, slv_rd, in_buf_win, csr_wr;
  logic [BAW-1:0] slv_off;
  logic           ctrl_wr, start_req, abort_req, count_ok;

  assign slv_wr     = slave_chipselect & slave_write;
  assign slv_rd     = slave_chipselect & slave_read;
  assign in_buf_win = slave_address[SLAVE_ADDRESSWIDTH-1];
  assign slv_off    = slave_address[BAW-1:0];
  assign csr_wr     = slv_wr & ~in_buf_win;
  assign ctrl_wr    = csr_wr & (slv_off == BAW'(CSR_CTRL));
  assign start_req  = ctrl_wr & slave_writedata[CTRL_START];
  assign abort_req  = ctrl_wr & slave_writedata[CTRL_ABORT];
  assign count_ok   = (count_q != '0) && (count_q <= DATAWIDTH'(NUMWORDS));

  // Beat bookkeeping
  logic                           busy, beat_done, last_beat, abort_now;
  logic [MASTER_ADDRESSWIDTH-1:0] beat_addr;
  logic [DATAWIDTH-1:0]           buf_rd_a, buf_rd_b;

  assign busy      = (state != IDLE);
  assign beat_done = ((state == WR) & ~master_waitrequest) |
                     ((state == RD_WAIT) & master_readdatavalid);
  assign last_beat = ((idx + IW'(1)) == xfer_len);
  // An abort written on the same edge as a beat boundary is honoured there too.
  assign abort_now = abort_pend | abort_req;
  // Natural truncation to MASTER_ADDRESSWIDTH gives the wrap-around.
  assign beat_addr = base_addr + (MASTER_ADDRESSWIDTH'(idx) * MASTER_ADDRESSWIDTH'(BYTES));

  xfer_buffer #(
    .NUMWORDS  (NUMWORDS),
    .DATAWIDTH (DATAWIDTH)
  ) u_buffer (
    .clk       (clk),
    .slv_we    (slv_wr & in_buf_win & ~busy),
    .slv_addr  (slv_off),
    .slv_wdata (slave_writedata),
    .eng_we    ((state == RD_WAIT) & master_readdatavalid),
    .eng_addr  (idx[BAW-1:0]),
    .eng_wdata (master_readdata),
    .rd_addr_a (slv_off),
    .rd_data_a (buf_rd_a),
    .rd_addr_b (idx[BAW-1:0]),
    .rd_data_b (buf_rd_b)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state and master command outputs
  always_comb begin
    next_state       = state;
    master_write     = 1'b0;
    master_read      = 1'b0;
    master_address   = '0;
    master_writedata = '0;
    case (state)
      IDLE: begin
        if (start_req && count_ok) begin
          next_state = slave_writedata[CTRL_DIR] ? RD_REQ : WR;
        end
      end
      WR: begin
        master_write     = 1'b1;
        master_address   = beat_addr;
        master_writedata = buf_rd_b;
        if (!master_waitrequest && (last_beat || abort_now)) begin
          next_state = IDLE;
        end
      end
      RD_REQ: begin
        master_read    = 1'b1;
        master_address = beat_addr;
        if (!master_waitrequest) begin
          // Aborting here abandons the accepted read; its data returns in
          // IDLE where readdatavalid is ignored.
          next_state = abort_now ? IDLE : RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (master_readdatavalid) begin
          next_state = (last_beat || abort_now) ? IDLE : RD_REQ;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // CSRs, status and beat index
  always_ff @(posedge clk) begin
    if (reset) begin
      dir_q      <= 1'b0;
      irq_en_q   <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      aborted_q  <= 1'b0;
      abort_pend <= 1'b0;
      base_addr  <= MASTER_ADDRESSWIDTH'(BASE_RESET);
      count_q    <= '0;
      idx        <= '0;
      xfer_len   <= '0;
    end else begin
      if (ctrl_wr) begin
        dir_q    <= slave_writedata[CTRL_DIR];
        irq_en_q <= slave_writedata[CTRL_IRQ_EN];
      end
      if (csr_wr && slv_off == BAW'(CSR_BASE_ADDR)) begin
        base_addr <= MASTER_ADDRESSWIDTH'(slave_writedata);
      end
      if (csr_wr && slv_off == BAW'(CSR_COUNT)) begin
        count_q <= slave_writedata;
      end

      if (state == IDLE) begin
        abort_pend <= 1'b0;
        if (start_req) begin
          if (count_ok) begin
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            aborted_q <= 1'b0;
            idx       <= '0;
            xfer_len  <= IW'(count_q);
          end else begin
            done_q    <= 1'b1;
            error_q   <= 1'b1;
            aborted_q <= 1'b0;
          end
        end
      end else begin
        if (abort_req) begin
          abort_pend <= 1'b1;
        end
        if (beat_done) begin
          idx <= idx + IW'(1);
        end
        if (next_state == IDLE) begin
          done_q     <= 1'b1;
          // Only flag aborted when the abort actually cut the transfer short.
          aborted_q  <= abort_now & ~(beat_done & last_beat);
          abort_pend <= 1'b0;
        end
      end
    end
  end

  // Slave read mux and registered read data
  logic [15:0]          status_word;
  logic [3:0]           ctrl_word;
  logic [DATAWIDTH-1:0] rd_mux;

  always_comb begin
    status_word                           = '0;
    status_word[STAT_BUSY]                = busy;
    status_word[STAT_DONE]                = done_q;
    status_word[STAT_ERROR]               = error_q;
    status_word[STAT_ABORTED]             = aborted_q;
    status_word[STAT_WORDS_LSB +: 8]      = 8'(idx);

    ctrl_word              = '0;
    ctrl_word[CTRL_DIR]    = dir_q;
    ctrl_word[CTRL_IRQ_EN] = irq_en_q;

    rd_mux = '0;
    if (in_buf_win) begin
      rd_mux = buf_rd_a;
    end else begin
      case (slv_off)
        BAW'(CSR_CTRL):      rd_mux = DATAWIDTH'(ctrl_word);
        BAW'(CSR_STATUS):    rd_mux = DATAWIDTH'(status_word);
        BAW'(CSR_BASE_ADDR): rd_mux = DATAWIDTH'(base_addr);
        BAW'(CSR_COUNT):     rd_mux = count_q;
        default:             rd_mux = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slave_readdata <= '0;
    end else if (slv_rd) begin
      slave_readdata <= rd_mux;
    end
  end

  assign irq = done_q & irq_en_q;

endmodule
